// File: rtl/config_chain_loader.sv
// Configuration chain loader: accepts bitstream words over valid/ready and
// serialises them LSB-first onto the fabric config shift chain.
module config_chain_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 1280,
    parameter int COUNT_WIDTH  = 11
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_WIDTH-1:0]  word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic                   config_enable,
    output logic                   config_out,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] bit_count
);

    localparam int SLOT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_BIT  = COUNT_WIDTH'(CHAIN_LENGTH - 1);
    localparam logic [SLOT_W-1:0]      LAST_SLOT = SLOT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] shreg;
    logic [SLOT_W-1:0]     slot;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Reaching the last chain bit wins over the end-of-word check, so the
    // tail of a partial final word is never shifted.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (word_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (bit_count == LAST_BIT)   state_nxt = DONE;
                else if (slot == LAST_SLOT)  state_nxt = LOAD;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg     <= '0;
            slot      <= '0;
            bit_count <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) bit_count <= '0;
                LOAD: begin
                    if (word_valid) begin
                        shreg <= word_in;
                        slot  <= '0;
                    end
                end
                SHIFT: begin
                    shreg     <= shreg >> 1;
                    bit_count <= bit_count + COUNT_WIDTH'(1);
                    slot      <= slot + SLOT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the state register directly; no input reaches an output.
    assign word_ready    = (state == LOAD);
    assign config_enable = (state == SHIFT);
    assign config_out    = shreg[0];
    assign busy          = (state == LOAD) || (state == SHIFT);
    assign done          = (state == DONE);

endmodule
